// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline stall/flush controller.
package pipeline_pkg;

  // Controller state
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } state_e;

  // Action chosen for the current cycle (freeze > flush > stall > advance)
  typedef enum logic [1:0] {
    ACT_ADV    = 2'd0,
    ACT_STALL  = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_FREEZE = 2'd3
  } act_e;

  // Stage index constants into stage_valid {W,M,E,D}
  localparam int unsigned STG_D = 0;
  localparam int unsigned STG_E = 1;
  localparam int unsigned STG_M = 2;
  localparam int unsigned STG_W = 3;

  localparam int unsigned NUM_STG = 4;
  localparam int unsigned RUN_W   = 3;

  // Per-stage load enables and clears
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_clr;
    logic idex_en;
    logic idex_clr;
    logic exmem_en;
    logic exmem_clr;
    logic memwb_en;
  } stage_ctrl_t;

  // Enables/clears that hold the pipeline quiet while in reset
  localparam stage_ctrl_t CTRL_RESET = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b1, idex_en: 1'b0,
    idex_clr: 1'b1, exmem_en: 1'b0, exmem_clr: 1'b1, memwb_en: 1'b0
  };

  // Map an action to the stage register controls
  function automatic stage_ctrl_t ctrl_for(input act_e act);
    stage_ctrl_t c;
    c = '0;
    case (act)
      ACT_ADV: begin
        c.pc_en    = 1'b1;
        c.ifid_en  = 1'b1;
        c.idex_en  = 1'b1;
        c.exmem_en = 1'b1;
        c.memwb_en = 1'b1;
      end
      ACT_STALL: begin
        // EX/MEM takes a bubble; the clear dominates its enable
        c.exmem_en  = 1'b1;
        c.exmem_clr = 1'b1;
        c.memwb_en  = 1'b1;
      end
      ACT_FLUSH: begin
        c.pc_en    = 1'b1;
        c.ifid_en  = 1'b1;
        c.ifid_clr = 1'b1;
        c.idex_en  = 1'b1;
        c.idex_clr = 1'b1;
        c.exmem_en = 1'b1;
        c.memwb_en = 1'b1;
      end
      ACT_FREEZE: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up, never wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/freeze controller for the 5-stage RV32I core.
// Control outputs are combinational; stage_valid and counters are registered.
// Optional macro PIPELINE_PERF_EN implements stall_cnt/flush_cnt; otherwise
// both are tied to zero.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic             mem_busy,
  input  logic             fetch_valid,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_en,
  output logic             idex_clr,
  output logic             exmem_en,
  output logic             exmem_clr,
  output logic             memwb_en,
  output logic [3:0]       stage_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e            state;
  logic [RUN_W-1:0]  run_cnt;
  logic              flush_pending;
  act_e              act;
  stage_ctrl_t       ctrl;

  // Pick this cycle's action; a flush deferred by a freeze fires on exit
  always_comb begin
    act = ACT_ADV;
    if (mem_busy) begin
      act = ACT_FREEZE;
    end else if (flush_req || (flush_pending && (state == FREEZE))) begin
      act = ACT_FLUSH;
    end else if (stall_req && (run_cnt < RUN_W'(STALL_LIMIT))) begin
      act = ACT_STALL;
    end
  end

  // Stage controls; reset forces every enable low and every clear high
  always_comb begin
    ctrl = ctrl_for(act);
    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end
  end

  assign pc_en     = ctrl.pc_en;
  assign ifid_en   = ctrl.ifid_en;
  assign ifid_clr  = ctrl.ifid_clr;
  assign idex_en   = ctrl.idex_en;
  assign idex_clr  = ctrl.idex_clr;
  assign exmem_en  = ctrl.exmem_en;
  assign exmem_clr = ctrl.exmem_clr;
  assign memwb_en  = ctrl.memwb_en;

  // State, stall run length, deferred flush and per-stage valid tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      run_cnt       <= '0;
      flush_pending <= 1'b0;
      stage_valid   <= '0;
    end else begin
      case (act)
        ACT_FREEZE: begin
          state <= FREEZE;
          if (flush_req) begin
            flush_pending <= 1'b1;
          end
        end
        ACT_FLUSH: begin
          state                <= RUN;
          run_cnt              <= '0;
          flush_pending        <= 1'b0;
          stage_valid[STG_W]   <= stage_valid[STG_M];
          stage_valid[STG_M]   <= stage_valid[STG_E];
          stage_valid[STG_E]   <= 1'b0;
          stage_valid[STG_D]   <= 1'b0;
        end
        ACT_STALL: begin
          state                <= STALL;
          run_cnt              <= run_cnt + RUN_W'(1);
          flush_pending        <= 1'b0;
          stage_valid[STG_W]   <= stage_valid[STG_M];
          stage_valid[STG_M]   <= 1'b0;
        end
        ACT_ADV: begin
          state                <= RUN;
          run_cnt              <= '0;
          flush_pending        <= 1'b0;
          stage_valid          <= {stage_valid[NUM_STG-2:0], fetch_valid};
        end
      endcase
    end
  end

`ifdef PIPELINE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = (act == ACT_STALL);
  assign flush_inc = (act == ACT_FLUSH);

  // Cycles spent in load-use stall
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  // Flush events
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
